// File: rtl/pinfilter_bank.sv
// Multi-channel GPIO noise filter: per-channel stability counter, registered edge pulses.
// Optional 2-flop input synchroniser enabled by defining PINFILTER_SYNC_EN.
module pinfilter_bank #(
    parameter int                 WIDTH     = 8,
    parameter int                 STABLE    = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             ena,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] pos_edge,
    output logic [WIDTH-1:0] neg_edge,
    output logic             changed
);

    localparam int CW_RAW = $clog2(STABLE + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [WIDTH-1:0] w_samp;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_flip;
    logic [CW-1:0]    w_cnt_nxt [WIDTH];

    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_pos;
    logic [WIDTH-1:0] r_neg;
    logic             r_changed;

`ifdef PINFILTER_SYNC_EN
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Two-flop synchroniser, free-running regardless of the sample strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    assign w_samp = r_sync2;
`else
    assign w_samp = din;
`endif

    // Per-channel next-count and flip decision; a matching sample discards any partial count.
    always_comb begin
        w_diff = w_samp ^ r_dout;
        w_flip = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (!ena) begin
                w_cnt_nxt[i] = r_cnt[i];
            end else if (!w_diff[i]) begin
                w_cnt_nxt[i] = {CW{1'b0}};
            end else if (r_cnt[i] == CNT_LAST) begin
                w_cnt_nxt[i] = {CW{1'b0}};
                w_flip[i]    = 1'b1;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
        end
    end

    // Filter state, filtered levels and edge pulses; pulses coincide with the new dout level.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= {CW{1'b0}};
            end
            r_dout    <= RESET_VAL;
            r_pos     <= {WIDTH{1'b0}};
            r_neg     <= {WIDTH{1'b0}};
            r_changed <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_dout    <= r_dout ^ w_flip;
            r_pos     <= w_flip & w_samp;
            r_neg     <= w_flip & ~w_samp;
            r_changed <= |w_flip;
        end
    end

    assign dout     = r_dout;
    assign pos_edge = r_pos;
    assign neg_edge = r_neg;
    assign changed  = r_changed;

endmodule

// File: doc/pinfilter_bank.md
# pinfilter_bank

Multi-channel, parametrised GPIO noise filter. It is the successor of the single-pin two-sample filter. Each of `WIDTH` channels optionally passes through a synchroniser, then a per-channel stability counter. The filtered output only changes after `STABLE` consecutive enabled samples disagree with it. Registered one-cycle edge pulses and an aggregate change flag are produced. The block sits between the cartridge/GPIO pads and the bus decode logic, and is driven by a shared sample strobe.

## Interface
- `WIDTH`, 8: number of independent channels (1..64).
- `STABLE`, 2: consecutive differing enabled samples required to flip an output (1..256).
- `RESET_VAL`, all ones (`{WIDTH{1'b1}}`): value of `dout` and the sync flops in reset (pads idle high).

Ports:
- `clk`, input, 1: single clock; all state is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `din`, input, WIDTH: raw pad inputs, asynchronous to `clk`.
- `ena`, input, 1: sample strobe; the filter advances only on cycles where it is high.
- `dout`, output, WIDTH: filtered, registered levels.
- `pos_edge`, output, WIDTH: one-`clk` pulse in the first cycle `dout[i]` shows 1 after being 0.
- `neg_edge`, output, WIDTH: one-`clk` pulse in the first cycle `dout[i]` shows 0 after being 1.
- `changed`, output, 1: registered OR of `pos_edge | neg_edge`, coincident with them.

## Operation
- Sample path `s[i]`:
  - With sync compiled in, `s[i]` is `din[i]` after two flops clocked every `clk`, independent of `ena`.
  - Otherwise `s[i] = din[i]`.
- Per channel there is a counter `cnt[i]`, width `$clog2(STABLE+1)`, minimum 1 bit.
- On each `clk` with `ena=1`:
  - `s[i] == dout[i]`: `cnt[i] <= 0`. This is a glitch rejection; any partial count is discarded.
  - `s[i] != dout[i]` and `cnt[i] == STABLE-1`: `dout[i] <= s[i]`, `cnt[i] <= 0`, and the matching edge pulse goes high next cycle.
  - `s[i] != dout[i]` otherwise: `cnt[i] <= cnt[i]+1`.
- `ena=0`: `cnt` and `dout` hold; edge pulses and `changed` are 0.
- `STABLE=1`: `dout` follows `s` on every enabled cycle, and the counter is never incremented.
- Channels are fully independent. Several channels may flip in the same cycle, and each raises its own pulse.
- Reset (`reset=1` at a clock edge), also mid-count:
  - `dout <= RESET_VAL`, all `cnt <= 0`.
  - Sync flops `<= RESET_VAL`.
  - `pos_edge`, `neg_edge` and `changed` `<= 0`.
  - `reset` has priority over `ena`.
- No edge pulse is generated by reset itself, or on the first cycle after reset.

## Timing
- Reset values: `dout=RESET_VAL`, `pos_edge=0`, `neg_edge=0`, `changed=0`.
- Latency with `ena` held high, sync out: `din` stable before edge k makes `dout` change after edge k+STABLE-1. Edge pulses are high for exactly the cycle after that edge.
- With sync in: add 2 `clk` cycles.
- With a sparse `ena`: latency is STABLE enabled cycles plus the time until the next `ena`.
- An edge pulse lasts exactly 1 `clk`, even if `ena` stays high. It never lasts longer than one cycle.
- All outputs are registered; there is no combinational path from `din` or `ena` to any output.

## Configuration
- `PINFILTER_SYNC_EN` defined: a 2-flop synchroniser is inserted per channel ahead of the counter, and latency is +2 `clk`. This is required for real pads.
- Not defined: `din` feeds the comparator directly. This is for on-chip, already-synchronous sources and benches.

## Test plan
- Reset, then `din=8'hFF`, `ena=1`: `dout=8'hFF`, and no pulses for 10 cycles. Assert reset mid-count: `cnt` clears, and `dout` holds `RESET_VAL`.
- `STABLE=2`, sync out, `din[0]` 1->0 before edge k:
  - `dout[0]=0` after edge k+1.
  - `neg_edge[0]=1` and `changed=1` for one cycle only.
  - Other bits are unchanged.
- `STABLE=4`, glitch: `din[3]` low for 3 enabled cycles then high -> `dout[3]` stays 1, with no pulse. Low for 4 cycles -> `dout[3]=0` and one `neg_edge[3]` pulse.
- `ena` toggling 1/0 each cycle, `STABLE=3`, `din[5]` 1->0: `dout[5]` changes only after the 3rd enabled sample, about 6 `clk` later. Counts hold while `ena=0`.
- Simultaneous events, sync in, `STABLE=2`: bits 0 and 7 rise together from 0, and bit 1 falls.
  - `pos_edge=8'h81` and `neg_edge=8'h02` in the same cycle, which is 4 `clk` after `din` changes.
  - `changed` is a single pulse.
- `STABLE=1`, sync out: toggle `din[2]` every cycle with `ena=1` -> `dout[2]` follows with 1-cycle latency, and alternating `pos_edge[2]`/`neg_edge[2]` pulse every cycle.
